// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all 16 input rows into a 4-input netlist and captures its 16-bit code.
// Optional macro STABILITY_CHECK_EN adds an early per-row sample and a sticky `unstable` flag.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED_CODE = 16'h5B30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        dut_out,
  output logic [3:0]  dut_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] code,
  output logic        match
`ifdef STABILITY_CHECK_EN
  ,
  output logic        unstable
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [7:0] LAST_CNT  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] EARLY_CNT = 8'(SETTLE_CYCLES - 2);

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  dut_in_q, dut_in_d;
  logic [15:0] code_q, code_d;
  logic        match_q, match_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        early_q, early_d;
  logic        unstable_q, unstable_d;
  logic        stab_en;

`ifdef STABILITY_CHECK_EN
  assign stab_en = 1'b1;
`else
  assign stab_en = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      cnt_q      <= '0;
      dut_in_q   <= '0;
      code_q     <= '0;
      match_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      early_q    <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      dut_in_q   <= dut_in_d;
      code_q     <= code_d;
      match_q    <= match_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      early_q    <= early_d;
      unstable_q <= unstable_d;
    end
  end

  // done is registered so that it rises together with the freshly computed match
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    dut_in_d   = dut_in_q;
    code_d     = code_q;
    match_d    = match_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    early_d    = early_q;
    unstable_d = unstable_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = SETTLE;
          row_d      = '0;
          cnt_d      = '0;
          dut_in_d   = '0;
          code_d     = '0;
          match_d    = 1'b0;
          busy_d     = 1'b1;
          unstable_d = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d  = IDLE;
          dut_in_d = '0;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (stab_en && SETTLE_CYCLES >= 2 && cnt_q == EARLY_CNT) begin
            early_d = dut_out;
          end
          if (cnt_q == LAST_CNT) begin
            code_d[4'd15 - row_q] = dut_out;
            if (stab_en && SETTLE_CYCLES >= 2 && dut_out != early_q) begin
              unstable_d = 1'b1;
            end
            if (row_q == 4'd15) begin
              state_d = DONE;
            end else begin
              row_d    = row_q + 4'd1;
              dut_in_d = row_q + 4'd1;
              cnt_d    = '0;
            end
          end
        end
      end
      DONE: begin
        match_d = (code_q == EXPECTED_CODE) && !unstable_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dut_in = dut_in_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign code   = code_q;
  assign match  = match_q;
`ifdef STABILITY_CHECK_EN
  assign unstable = unstable_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with stub netlists of known truth tables.
// Define STABILITY_CHECK_EN to also exercise the unstable flag.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int failed    = 0;

  // Stub modes: 0 = in[3]&in[2], 1 = LUT 0x5B30, 2 = in[0], 3 = constant 1
  function automatic logic stub_f(input logic [1:0] mode, input logic [3:0] x);
    logic [15:0] lut;
    lut = 16'h5B30;
    case (mode)
      2'd0:    return x[3] & x[2];
      2'd1:    return lut[4'd15 - x];
      2'd2:    return x[0];
      default: return 1'b1;
    endcase
  endfunction

  logic        start4 = 1'b0, abort4 = 1'b0, delay4 = 1'b0;
  logic [1:0]  mode4 = 2'd0;
  logic [3:0]  din4;
  logic        dout4, busy4, done4, match4, d4a, d4b;
  logic [15:0] code4;

  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [1:0]  mode1 = 2'd2;
  logic [3:0]  din1;
  logic        dout1, busy1, done1, match1;
  logic [15:0] code1;

  always @(posedge clk) begin
    d4a <= stub_f(2'd1, din4);
    d4b <= d4a;
  end
  assign dout4 = delay4 ? d4b : stub_f(mode4, din4);
  assign dout1 = stub_f(mode1, din1);

`ifdef STABILITY_CHECK_EN
  logic        unst4, unst1;
  logic        start2 = 1'b0, abort2 = 1'b0;
  logic [3:0]  din2;
  logic        dout2, busy2, done2, match2, unst2, d2a, d2b;
  logic [15:0] code2;

  always @(posedge clk) begin
    d2a <= stub_f(2'd1, din2);
    d2b <= d2a;
  end
  assign dout2 = d2b;

  truth_table_sweeper #(.SETTLE_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .dut_out(dout2),
    .dut_in(din2), .busy(busy2), .done(done2), .code(code2), .match(match2),
    .unstable(unst2)
  );
`endif

  truth_table_sweeper #(.SETTLE_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .dut_out(dout4),
    .dut_in(din4), .busy(busy4), .done(done4), .code(code4), .match(match4)
`ifdef STABILITY_CHECK_EN
    , .unstable(unst4)
`endif
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .dut_out(dout1),
    .dut_in(din1), .busy(busy1), .done(done1), .code(code1), .match(match1)
`ifdef STABILITY_CHECK_EN
    , .unstable(unst1)
`endif
  );

  task automatic start_u4();
    @(negedge clk) start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
  endtask

  task automatic check_u4_zero(input string name);
    logic [22:0] got;
    got = {din4, busy4, done4, code4, match4};
`ifdef STABILITY_CHECK_EN
    got[0] = got[0] | unst4;
`endif
    tests_run++;
    if (got !== 23'd0) begin
      failed++;
      $display("[TB] FAIL %s: din=%h busy=%b done=%b code=%h match=%b, required all zero",
               name, din4, busy4, done4, code4, match4);
    end
  endtask

  // Runs the remaining 64 settle edges plus the DONE edge of an S=4 sweep
  task automatic finish_u4_sweep(input string name, input logic [15:0] exp_code,
                                 input logic exp_match, input bit check_din);
    int early_done = 0;
    int din_errs   = 0;
    logic [3:0] exp_din;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (done4 !== 1'b0) early_done++;
      exp_din = (k >= 64) ? 4'd15 : 4'(k / 4);
      if (din4 !== exp_din) din_errs++;
    end
    tests_run++;
    if (early_done != 0) begin
      failed++;
      $display("[TB] FAIL %s_early_done: done seen %0d times before edge 65, required 0", name, early_done);
    end
    if (check_din) begin
      tests_run++;
      if (din_errs != 0) begin
        failed++;
        $display("[TB] FAIL %s_din_steps: %0d wrong dut_in values, required 0", name, din_errs);
      end
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done4 !== 1'b1 || busy4 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL %s_done: done=%b busy=%b, required done=1 busy=0", name, done4, busy4);
    end
    tests_run++;
    if (code4 !== exp_code || match4 !== exp_match) begin
      failed++;
      $display("[TB] FAIL %s_result: code=%h match=%b, required code=%h match=%b",
               name, code4, match4, exp_code, exp_match);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done4 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL %s_done_pulse: done=%b one cycle later, required 0", name, done4);
    end
  endtask

  task automatic test_reset();
    #1;
    check_u4_zero("reset_initial");
    @(negedge clk) rst = 1'b0;
    mode4 = 2'd3;
    start_u4();
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_u4_zero("reset_mid_sweep");
    @(negedge clk) rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check_u4_zero("reset_no_resume");
  endtask

  task automatic test_and2_latency();
    mode4 = 2'd0;
    start_u4();
    tests_run++;
    if (busy4 !== 1'b1 || din4 !== 4'd0) begin
      failed++;
      $display("[TB] FAIL and2_busy: busy=%b din=%h, required busy=1 din=0", busy4, din4);
    end
    finish_u4_sweep("and2", 16'h000F, 1'b0, 1'b0);
  endtask

  task automatic test_lut_match();
    mode4 = 2'd1;
    start_u4();
    finish_u4_sweep("lut", 16'h5B30, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (code4 !== 16'h5B30 || match4 !== 1'b1 || busy4 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL lut_hold: code=%h match=%b busy=%b, required 5b30 1 0", code4, match4, busy4);
    end
  endtask

  task automatic test_settle1_back_to_back();
    int dones = 0;
    int done_edge = 0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      start1 = ((k >= 2 && k <= 7) || k == 16);
      @(posedge clk);
      #1 start1 = 1'b0;
      if (done1 === 1'b1) begin
        dones++;
        if (done_edge == 0) done_edge = k;
        tests_run++;
        if (code1 !== 16'h5555 || match1 !== 1'b0) begin
          failed++;
          $display("[TB] FAIL s1_result: code=%h match=%b, required 5555 0", code1, match1);
        end
      end
    end
    tests_run++;
    if (dones != 1 || done_edge != 17) begin
      failed++;
      $display("[TB] FAIL s1_done_count: dones=%0d first at edge %0d, required 1 at edge 17", dones, done_edge);
    end
    tests_run++;
    if (busy1 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL s1_no_queue: busy=%b, required 0", busy1);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    mode4 = 2'd3;
    @(negedge clk) begin start4 = 1'b1; abort4 = 1'b1; end
    @(posedge clk);
    #1 begin start4 = 1'b0; abort4 = 1'b0; end
    tests_run++;
    if (busy4 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL start_with_abort: busy=%b, required 0", busy4);
    end
    start_u4();
    repeat (29) @(posedge clk);
    #1;
    tests_run++;
    if (din4 !== 4'd7) begin
      failed++;
      $display("[TB] FAIL abort_row: din=%h, required 7", din4);
    end
    @(negedge clk) abort4 = 1'b1;
    @(posedge clk);
    #1 abort4 = 1'b0;
    tests_run++;
    if (busy4 !== 1'b0 || din4 !== 4'd0 || done4 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL abort_stop: busy=%b din=%h done=%b, required 0 0 0", busy4, din4, done4);
    end
    tests_run++;
    if (code4 !== 16'hFE00 || match4 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL abort_partial: code=%h match=%b, required fe00 0", code4, match4);
    end
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (done4 === 1'b1 || busy4 === 1'b1) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      failed++;
      $display("[TB] FAIL abort_no_done: %0d active cycles after abort, required 0", dones);
    end
    start_u4();
    finish_u4_sweep("after_abort", 16'hFFFF, 1'b0, 1'b0);
  endtask

`ifdef STABILITY_CHECK_EN
  task automatic test_stability();
    int dones = 0;
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      if (done2 === 1'b1) dones++;
    end
    tests_run++;
    if (dones != 1 || unst2 !== 1'b1 || match2 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL stab_s2: dones=%0d unstable=%b match=%b, required 1 1 0", dones, unst2, match2);
    end
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    tests_run++;
    if (unst2 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL stab_clear: unstable=%b, required 0", unst2);
    end
    delay4 = 1'b1;
    start_u4();
    finish_u4_sweep("stab_s4", 16'h5B30, 1'b1, 1'b0);
    tests_run++;
    if (unst4 !== 1'b0 || unst1 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL stab_s4_flag: unstable4=%b unstable1=%b, required 0 0", unst4, unst1);
    end
    delay4 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_and2_latency();
    test_lut_match();
    test_settle1_back_to_back();
    test_abort();
`ifdef STABILITY_CHECK_EN
    test_stability();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Stimulus/response end for the 4-input combinational logic netlists; complement to the gate-level implementations, which map inputs to one output.
- Drives all 16 input combinations into a DUT netlist and waits a programmable settle time per row.
- Samples the DUT output per row and assembles the 16-bit truth-table code in the hex form used to name designs (e.g. 0x5B30).
- Compares the code against an expected value; used in simulation harnesses and on-chip self-check wrappers around synthesized circuits.

Parameters:
- SETTLE_CYCLES, 4, clock cycles each input row is held before the output is sampled; legal range 1..255.
- EXPECTED_CODE, 16'h5B30, reference truth-table code for the `match` output.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sweep; accepted only in IDLE
- abort  input  1  cancel an in-progress sweep
- dut_out  input  1  output of the circuit under test
- dut_in  output  4  drive vector to the DUT; dut_in[3:0] = row index r
- busy  output  1  high from the cycle after start is accepted until the done pulse
- done  output  1  one-cycle pulse when code/match are valid
- code  output  16  captured truth table; code[15-r] = dut_out sampled for row r (row 0 is the MSB)
- match  output  1  code == EXPECTED_CODE; valid from done, held until the next accepted start
- unstable  output  1  present only with STABILITY_CHECK_EN (see below)

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted: state=IDLE, dut_in=0, busy=0, done=0, code=0, match=0, unstable=0, row and settle counters=0.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - If start=1 (and abort=0) at a clock edge: row<=0, dut_in<=0, cnt<=0, code<=0, match<=0, state<=SETTLE.
  - start=1 together with abort=1: start is ignored.
- SETTLE:
  - cnt increments each cycle; dut_in is held constant.
  - On the cycle with cnt==SETTLE_CYCLES-1, dut_out is captured into code[15-row].
  - If row==15 at that cycle: state<=DONE.
  - Otherwise: row<=row+1, dut_in<=row+1, cnt<=0.
- DONE:
  - match<=({captured code}==EXPECTED_CODE).
  - done=1 for exactly this one cycle; busy=0.
  - state<=IDLE.
- Latency: done is high during the cycle that follows the (16*SETTLE_CYCLES+1)th rising edge after the edge that accepted start.
- Counter widths: row is 4 bits and never wraps past 15 during a sweep. cnt is 8 bits.
- abort=1 in SETTLE:
  - Next edge: state<=IDLE, dut_in<=0, busy<=0, no done pulse.
  - code and match keep their partially updated and cleared values.
  - abort in IDLE or DONE has no effect; DONE still completes.
- start=1 while busy is ignored; it does not queue.
- code and match hold their values in IDLE until the next accepted start.
- Reset asserted mid-sweep: all outputs immediately take their reset values; the sweep does not resume.

Optional Feature:
- Macro: STABILITY_CHECK_EN.
- Defined:
  - In each row, dut_out is also captured on the cycle with cnt==SETTLE_CYCLES-2.
  - If that value differs from the final sample, the sticky flag `unstable` is set.
  - `unstable` is cleared on an accepted start and by reset.
  - When SETTLE_CYCLES==1, no early sample exists and `unstable` stays 0.
  - match is forced to 0 at DONE if unstable=1.
- Undefined: the port `unstable` and its logic are absent; match depends only on code.

Test Plan:
- Reset mid-sweep, then stub DUT out=dut_in[3]&dut_in[2], SETTLE_CYCLES=4, pulse start -> after reset all outputs are 0. After start, done is high on the 66th cycle after the start edge, code=16'h000F, match=0.
- Stub DUT implementing function 0x5B30 (4-bit LUT), defaults -> code=16'h5B30, match=1. dut_in steps 0..15, each held 4 cycles.
- Stub out=dut_in[0], SETTLE_CYCLES=1 -> code=16'h5555, done 17 cycles after start. start pulses during busy are ignored; no second done.
- Constant-1 DUT, abort asserted at row 7 -> next cycle busy=0, dut_in=0, no done. A fresh start then yields code=16'hFFFF.
- STABILITY_CHECK_EN with a DUT delayed by 2 cycles through flops, SETTLE_CYCLES=2 -> unstable=1 and match=0. The same DUT with SETTLE_CYCLES=4 -> unstable=0.
